// File: rtl/fp_window_accum.sv
// fp_window_accum: decodes 8-bit (S,E,F) floats to signed integers, sums
// WINDOW accepted samples with saturation, tracks peak magnitude and
// presents one result per window on a valid/ready output handshake.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clr                 synchronous clear of partial window / pending result
//   in_valid/in_ready   sample handshake; in_s/in_e/in_f carry the sample
//   out_valid/out_ready result handshake
//   sum_out             signed saturated window sum (ACC_W bits)
//   peak_out            largest |F<<E| seen in the window
//   sat_out             saturation occurred somewhere in the window
module fp_window_accum #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_s,
  input  logic [2:0]              in_e,
  input  logic [3:0]              in_f,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] sum_out,
  output logic [10:0]             peak_out,
  output logic                    sat_out
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);
  localparam int unsigned MAG_W = 11;
  localparam int unsigned VAL_W = 12;
  localparam int unsigned EXT_W = ACC_W + 1;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MAG_W-1:0]          peak_q, peak_d;
  logic                      sat_q, sat_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]   sum_out_q, sum_out_d;
  logic [MAG_W-1:0]          peak_out_q, peak_out_d;
  logic                      sat_out_q, sat_out_d;

  logic [MAG_W-1:0]          mag;
  logic [VAL_W-1:0]          val;
  logic [EXT_W-1:0]          sum_ext;
  logic                      ovf;
  logic signed [ACC_W-1:0]   acc_sat;
  logic [MAG_W-1:0]          peak_new;
  logic                      accept;
  logic                      last;

  // Sample decode and saturating add, evaluated one guard bit wider than acc.
  always_comb begin
    mag      = {7'b0, in_f} << in_e;
    val      = in_s ? -{1'b0, mag} : {1'b0, mag};
    sum_ext  = {acc_q[ACC_W-1], acc_q} + {{(EXT_W-VAL_W){val[VAL_W-1]}}, val};
    ovf      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    if (!ovf) begin
      acc_sat = sum_ext[ACC_W-1:0];
    end else if (sum_ext[ACC_W]) begin
      acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
    peak_new = (mag > peak_q) ? mag : peak_q;
  end

  assign in_ready = (state_q == ACCUM) && !clr;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_q == CNT_W'(WINDOW - 1));

  // Next-state logic; clr outranks everything except reset.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    peak_d      = peak_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    sum_out_d   = sum_out_q;
    peak_out_d  = peak_out_q;
    sat_out_d   = sat_out_q;
    if (clr) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      peak_d      = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              // Final sample: publish the result and restart the window.
              sum_out_d   = acc_sat;
              peak_out_d  = peak_new;
              sat_out_d   = sat_q | ovf;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              peak_d      = '0;
              sat_d       = 1'b0;
              state_d     = HOLD;
            end else begin
              acc_d  = acc_sat;
              cnt_d  = cnt_q + CNT_W'(1);
              peak_d = peak_new;
              sat_d  = sat_q | ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      peak_q      <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sum_out_q   <= '0;
      peak_out_q  <= '0;
      sat_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      peak_q      <= peak_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      sum_out_q   <= sum_out_d;
      peak_out_q  <= peak_out_d;
      sat_out_q   <= sat_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum_out   = sum_out_q;
  assign peak_out  = peak_out_q;
  assign sat_out   = sat_out_q;

endmodule
